// File: rtl/mm_job_scheduler.sv
// Matrix-multiply job sequencer.
// Accepts one job descriptor at a time and programs the loader's dimension
// configuration. It then issues the A and B DMA read commands; A is skipped
// when the job reuses an A tile that is still resident. It follows the
// loader's start/done handshake and reports a tagged completion. A job with
// a zero dimension, or one whose wait state times out, completes with err=1.
module mm_job_scheduler #(
    parameter int N1           = 4,
    parameter int N2           = 4,
    parameter int P_B          = 1,
    parameter int MATRIXSIZE_W = 16,
    parameter int LEN_W        = 32,
    parameter int TAG_W        = 4,
    parameter int TIMEOUT_W    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [MATRIXSIZE_W-1:0] job_M2,
    input  logic [MATRIXSIZE_W-1:0] job_M1dN1,
    input  logic [MATRIXSIZE_W-1:0] job_M3dN2,
    input  logic                    job_reuse_A,
    input  logic [TAG_W-1:0]        job_tag,
    output logic [MATRIXSIZE_W-1:0] M2,
    output logic [MATRIXSIZE_W-1:0] M1dN1,
    output logic [MATRIXSIZE_W-1:0] M3dN2,
    output logic                    cmd_A_valid,
    input  logic                    cmd_A_ready,
    output logic [LEN_W-1:0]        cmd_A_len,
    output logic                    cmd_B_valid,
    input  logic                    cmd_B_ready,
    output logic [LEN_W-1:0]        cmd_B_len,
    input  logic                    start_multiply,
    input  logic                    done_multiply,
    output logic                    cmp_valid,
    input  logic                    cmp_ready,
    output logic [TAG_W-1:0]        cmp_tag,
    output logic                    cmp_err,
    input  logic [TIMEOUT_W-1:0]    timeout_limit,
    output logic                    busy,
    output logic [15:0]             jobs_done
);

    // The B product is formed at full width before the divide by P_B.
    // Truncating to LEN_W first would change the quotient.
    localparam int PROD_W = 2 * MATRIXSIZE_W + 32;

    typedef enum logic [2:0] {
        IDLE, LOAD, CMD_A, CMD_B, WAIT_START, WAIT_DONE, WAIT_RELEASE, COMPLETE
    } state_t;

    state_t state, state_nxt;

    logic [MATRIXSIZE_W-1:0] d_m2, d_m1, d_m3;
    logic                    d_reuse;
    logic [TAG_W-1:0]        d_tag;
    logic                    a_loaded;
    logic [TIMEOUT_W-1:0]    tcnt;

    logic             err_nxt;
    logic             set_a;
    logic             clr_a;
    logic             timed_out;
    logic             bad_dim;
    logic             waiting;
    logic [LEN_W-1:0] len_a;
    logic [LEN_W-1:0] len_b;

    assign bad_dim = (d_m2 == '0) || (d_m1 == '0) || (d_m3 == '0);
    assign waiting = (state == WAIT_START) || (state == WAIT_DONE) || (state == WAIT_RELEASE);

    // The product is taken modulo 2^LEN_W, so narrowing the operands first
    // still gives the truncated result.
    assign len_a = LEN_W'(d_m1) * LEN_W'(N1) * LEN_W'(d_m2);
    assign len_b = LEN_W'((PROD_W'(d_m2) * PROD_W'(d_m3) * PROD_W'(N2)) / PROD_W'(P_B));

    assign job_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign cmd_A_valid = (state == CMD_A);
    assign cmd_B_valid = (state == CMD_B);
    assign cmp_valid   = (state == COMPLETE);

    // Next-state logic. The awaited condition is checked before the timeout,
    // so the condition wins when both happen in the same cycle.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        set_a     = 1'b0;
        clr_a     = 1'b0;
        timed_out = (timeout_limit != '0) && (tcnt == timeout_limit - TIMEOUT_W'(1));
        case (state)
            IDLE: begin
                if (job_valid) state_nxt = LOAD;
            end
            LOAD: begin
                if (bad_dim) begin
                    state_nxt = COMPLETE;
                    err_nxt   = 1'b1;
                    clr_a     = 1'b1;
                end else if (d_reuse && a_loaded) begin
                    state_nxt = CMD_B;
                end else begin
                    state_nxt = CMD_A;
                end
            end
            CMD_A: begin
                if (cmd_A_ready) begin
                    set_a     = 1'b1;
                    state_nxt = CMD_B;
                end
            end
            CMD_B: begin
                if (cmd_B_ready) state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (start_multiply) begin
                    state_nxt = WAIT_DONE;
                end else if (timed_out) begin
                    state_nxt = COMPLETE;
                    err_nxt   = 1'b1;
                    clr_a     = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (done_multiply) begin
                    state_nxt = WAIT_RELEASE;
                end else if (timed_out) begin
                    state_nxt = COMPLETE;
                    err_nxt   = 1'b1;
                    clr_a     = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (!done_multiply) begin
                    state_nxt = COMPLETE;
                end else if (timed_out) begin
                    state_nxt = COMPLETE;
                    err_nxt   = 1'b1;
                    clr_a     = 1'b1;
                end
            end
            COMPLETE: begin
                if (cmp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Timeout counter: cleared on every state change, counts only while waiting.
    always_ff @(posedge clk) begin
        if (rst)                     tcnt <= '0;
        else if (state_nxt != state) tcnt <= '0;
        else if (waiting)            tcnt <= tcnt + TIMEOUT_W'(1);
    end

    // Capture the descriptor on the accept handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_m2    <= '0;
            d_m1    <= '0;
            d_m3    <= '0;
            d_reuse <= 1'b0;
            d_tag   <= '0;
        end else if (state == IDLE && job_valid) begin
            d_m2    <= job_M2;
            d_m1    <= job_M1dN1;
            d_m3    <= job_M3dN2;
            d_reuse <= job_reuse_A;
            d_tag   <= job_tag;
        end
    end

    // Loader configuration and DMA lengths are loaded only in LOAD.
    // They stay stable through the command handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            M2        <= '0;
            M1dN1     <= '0;
            M3dN2     <= '0;
            cmd_A_len <= '0;
            cmd_B_len <= '0;
        end else if (state == LOAD) begin
            M2        <= d_m2;
            M1dN1     <= d_m1;
            M3dN2     <= d_m3;
            cmd_A_len <= len_a;
            cmd_B_len <= len_b;
        end
    end

    // Latch the completion tag and error on entry to COMPLETE.
    // They hold until the host accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_tag <= '0;
            cmp_err <= 1'b0;
        end else if (state != COMPLETE && state_nxt == COMPLETE) begin
            cmp_tag <= d_tag;
            cmp_err <= err_nxt;
        end
    end

    // Track whether the loader holds a valid A tile. Any error drops it, so
    // the next reuse job fetches A again.
    always_ff @(posedge clk) begin
        if (rst)        a_loaded <= 1'b0;
        else if (clr_a) a_loaded <= 1'b0;
        else if (set_a) a_loaded <= 1'b1;
    end

    // Count error-free completions at the host handshake.
    always_ff @(posedge clk) begin
        if (rst)                                       jobs_done <= '0;
        else if (state == COMPLETE && cmp_ready && !cmp_err) jobs_done <= jobs_done + 16'd1;
    end

endmodule
